sram_arbiter: RTL and testbench

- Shares the single external 256K x 16 asynchronous SRAM between NREQ bus requesters (CPU, debug bridge, video/DMA).
- Arbitration is round-robin. Each granted transfer is sequenced through setup, wait-stated access and hold phases.
- Drives the SRAM pins directly, replacing the single-cycle, fixed-priority access path.
- Sits between the requester req/ack ports and the board RAM pins.

---
 rtl/sram_arbiter_if.sv | 32 +++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bus and SRAM control pins for sram_arbiter.
// The bidirectional data pin stays a plain module port so the tri-state resolves at the pad.
interface sram_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 18,
    parameter int unsigned DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    write;
    logic [2*NREQ-1:0]  sel;
    logic [AW*NREQ-1:0] adr;
    logic [DW*NREQ-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               RAMCS;
    logic               RAMWE;
    logic               RAMOE;
    logic               RAMLB;
    logic               RAMUB;
    logic [AW-1:0]      ADR;

    modport master (
        output req, write, sel, adr, wdata,
        input  ack, rdata, busy, RAMCS, RAMWE, RAMOE, RAMLB, RAMUB, ADR
    );

    modport slave (
        input  req, write, sel, adr, wdata,
        output ack, rdata, busy, RAMCS, RAMWE, RAMOE, RAMLB, RAMUB, ADR
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between NREQ requesters.
// Each grant runs SETUP, ACCESS (WAIT+1 cycles) and HOLD; all pins come from registers.
module sram_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 18,
    parameter int unsigned DW   = 16,
    parameter int unsigned WAIT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    sram_arbiter_if.slave bus,
    inout  wire [DW-1:0]  io_dat
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    state_e          r_state;
    logic [3:0]      r_cnt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_g;
    logic            r_write;
    logic            r_dat_oe;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_ack_d;
    logic            r_cs;
    logic            r_we;
    logic            r_oe;
    logic            r_lb;
    logic            r_ub;
    logic [AW-1:0]   r_adr;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic [IW:0]     w_sum;
    logic [1:0]      w_sel;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_wdata;
    logic            w_wr;

    // A requester acked in the previous cycle may not win the very next arbitration.
    assign w_elig = bus.req & ~r_ack_d;

    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_sum   = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_sel   = bus.sel[2*w_win +: 2];
    assign w_adr   = bus.adr[AW*w_win +: AW];
    assign w_wdata = bus.wdata[DW*w_win +: DW];
    assign w_wr    = bus.write[w_win];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_last   <= IW'(NREQ - 1);
            r_g      <= '0;
            r_write  <= 1'b0;
            r_dat_oe <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ack    <= '0;
            r_ack_d  <= '0;
            r_cs     <= 1'b1;
            r_we     <= 1'b1;
            r_oe     <= 1'b1;
            r_lb     <= 1'b1;
            r_ub     <= 1'b1;
            r_adr    <= '0;
        end else begin
            r_ack_d <= r_ack;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state  <= StSetup;
                        r_g      <= w_win;
                        r_last   <= w_win;
                        r_write  <= w_wr;
                        r_wdata  <= w_wdata;
                        r_adr    <= w_adr;
                        r_cs     <= 1'b0;
                        r_oe     <= w_wr;
                        r_we     <= 1'b1;
                        r_lb     <= ~w_sel[0];
                        r_ub     <= ~w_sel[1];
                        r_dat_oe <= w_wr;
                    end
                end
                StSetup: begin
                    r_state <= StAccess;
                    r_cnt   <= 4'(WAIT);
                    r_we    <= ~r_write;
                end
                StAccess: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_write) begin
                            r_rdata <= io_dat;
                        end
                        r_state    <= StHold;
                        r_we       <= 1'b1;
                        r_oe       <= 1'b1;
                        r_ack[r_g] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StHold: begin
                    r_state  <= StIdle;
                    r_ack    <= '0;
                    r_cs     <= 1'b1;
                    r_lb     <= 1'b1;
                    r_ub     <= 1'b1;
                    r_dat_oe <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_dat    = r_dat_oe ? r_wdata : {DW{1'bz}};
    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;
    assign bus.busy  = (r_state != StIdle);
    assign bus.RAMCS = r_cs;
    assign bus.RAMWE = r_we;
    assign bus.RAMOE = r_oe;
    assign bus.RAMLB = r_lb;
    assign bus.RAMUB = r_ub;
    assign bus.ADR   = r_adr;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT=1 main instance with an SRAM model,
// plus WAIT=0 and WAIT=15 instances for latency checks.
module tb_sram_arbiter;
    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    wire [DW-1:0] w_dat;
    wire [DW-1:0] w_dat0;
    wire [DW-1:0] w_dat15;

    logic          ld_en  = 1'b0;
    logic [AW-1:0] ld_adr = '0;
    logic [DW-1:0] ld_dat = '0;
    logic [DW-1:0] mem [0:262143];

    int          c0, nacks, idle, nseq, we_low, oe0, oe15, c_a0, c_a15, n;
    int          acyc [3];
    logic [15:0] ard [3];
    logic [2:0]  aseq [4];
    int          acy [4];
    logic        ack1_seen;
    logic [2:0]  v, v0, v15;
    logic [15:0] rd0, rd15;

    sram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    sram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus0 ();
    sram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus15 ();

    sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .io_dat(w_dat)
    );
    sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0), .io_dat(w_dat0)
    );
    sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT(15)) u_dut15 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus15), .io_dat(w_dat15)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM models: drive data while selected, output-enabled and not writing.
    assign w_dat = (!bus.RAMCS && !bus.RAMOE && bus.RAMWE) ? mem[bus.ADR] : {DW{1'bz}};
    assign w_dat0 = (!bus0.RAMCS && !bus0.RAMOE && bus0.RAMWE) ?
                    (bus0.ADR[15:0] ^ 16'hC3C3) : {DW{1'bz}};
    assign w_dat15 = (!bus15.RAMCS && !bus15.RAMOE && bus15.RAMWE) ?
                     (bus15.ADR[15:0] ^ 16'hC3C3) : {DW{1'bz}};

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_adr] <= ld_dat;
        end else if (!bus.RAMCS && !bus.RAMWE) begin
            if (!bus.RAMLB) mem[bus.ADR][7:0] <= w_dat[7:0];
            if (!bus.RAMUB) mem[bus.ADR][15:8] <= w_dat[15:8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en  = 1'b1;
        ld_adr = a;
        ld_dat = d;
        tick();
        ld_en  = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output logic [2:0] av, output int an);
        av = '0;
        an = 0;
        while (av == 3'b000 && an < limit) begin
            tick();
            an++;
            av = bus.ack;
        end
    endtask

    initial begin
        bus.req = '0;   bus.write = '0;   bus.sel = '0;   bus.adr = '0;   bus.wdata = '0;
        bus0.req = '0;  bus0.write = '0;  bus0.sel = '0;  bus0.adr = '0;  bus0.wdata = '0;
        bus15.req = '0; bus15.write = '0; bus15.sel = '0; bus15.adr = '0; bus15.wdata = '0;

        // Reset state, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_adr", bus.ADR, 0);
        chk("rst_pins", {bus.RAMCS, bus.RAMWE, bus.RAMOE, bus.RAMLB, bus.RAMUB}, 5'b11111);

        preload(18'h00010, 16'h1111);
        preload(18'h00020, 16'h2222);
        preload(18'h00030, 16'h3333);
        preload(18'h00123, 16'hBEEF);
        preload(18'h3FFFF, 16'h1234);
        rst_n = 1'b1;
        tick();

        // Three simultaneous requesters: served 0,1,2 five cycles apart
        bus.adr   = {18'h00030, 18'h00020, 18'h00010};
        bus.sel   = 6'b111111;
        bus.write = 3'b000;
        bus.req   = 3'b111;
        c0 = cyc; nacks = 0; idle = 0;
        for (int i = 0; i < 3; i++) begin
            acyc[i] = -1;
            ard[i]  = '0;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (bus.ack[i]) begin
                    acyc[i]    = cyc - c0;
                    ard[i]     = bus.rdata;
                    bus.req[i] = 1'b0;
                    nacks++;
                end
            end
            if (!bus.busy && nacks > 0 && nacks < 3) idle++;
        end
        chk("rr3_ack0_cyc", acyc[0], 4);
        chk("rr3_ack1_cyc", acyc[1], 9);
        chk("rr3_ack2_cyc", acyc[2], 14);
        chk("rr3_rd0", ard[0], 16'h1111);
        chk("rr3_rd1", ard[1], 16'h2222);
        chk("rr3_rd2", ard[2], 16'h3333);
        chk("rr3_idle_gaps", idle, 2);

        // Single read by requester 1, WAIT=1
        bus.adr[AW +: AW] = 18'h00123;
        bus.sel = 6'b001100;
        bus.req = 3'b010;
        tick();
        chk("rd_c1_busy", bus.busy, 1);
        chk("rd_c1_cs_oe_we", {bus.RAMCS, bus.RAMOE, bus.RAMWE}, 3'b001);
        chk("rd_c1_adr", bus.ADR, 18'h00123);
        chk("rd_c1_ub_lb", {bus.RAMUB, bus.RAMLB}, 2'b00);
        tick();
        chk("rd_c2_oe_we", {bus.RAMOE, bus.RAMWE}, 2'b01);
        chk("rd_c2_ack", bus.ack, 0);
        tick();
        chk("rd_c3_oe_we", {bus.RAMOE, bus.RAMWE}, 2'b01);
        chk("rd_c3_ack", bus.ack, 0);
        tick();
        chk("rd_c4_ack", bus.ack, 3'b010);
        chk("rd_c4_rdata", bus.rdata, 16'hBEEF);
        chk("rd_c4_cs_oe_we", {bus.RAMCS, bus.RAMOE, bus.RAMWE}, 3'b011);
        bus.req = '0;
        tick();
        chk("rd_c5_busy", bus.busy, 0);
        chk("rd_c5_cs_oe_we", {bus.RAMCS, bus.RAMOE, bus.RAMWE}, 3'b111);

        // Single high-byte write by requester 0
        bus.adr[0 +: AW]   = 18'h3FFFF;
        bus.wdata[0 +: DW] = 16'hA5A5;
        bus.sel   = 6'b000010;
        bus.write = 3'b001;
        bus.req   = 3'b001;
        we_low = 0;
        tick();
        if (!bus.RAMWE) we_low++;
        chk("wr_c1_oe_we", {bus.RAMOE, bus.RAMWE}, 2'b11);
        chk("wr_c1_ub_lb", {bus.RAMUB, bus.RAMLB}, 2'b01);
        chk("wr_c1_dat", w_dat, 16'hA5A5);
        chk("wr_c1_adr", bus.ADR, 18'h3FFFF);
        tick();
        if (!bus.RAMWE) we_low++;
        chk("wr_c2_we", bus.RAMWE, 0);
        chk("wr_c2_dat", w_dat, 16'hA5A5);
        tick();
        if (!bus.RAMWE) we_low++;
        tick();
        if (!bus.RAMWE) we_low++;
        chk("wr_c4_ack", bus.ack, 3'b001);
        chk("wr_c4_cs_we", {bus.RAMCS, bus.RAMWE}, 2'b01);
        chk("wr_c4_dat", w_dat, 16'hA5A5);
        bus.req   = '0;
        bus.write = '0;
        tick();
        if (!bus.RAMWE) we_low++;
        chk("wr_c5_busy", bus.busy, 0);
        chk("wr_we_low_cycles", we_low, 2);
        chk("wr_mem", mem[18'h3FFFF], 16'hA534);
        chk("wr_rdata_kept", bus.rdata, 16'hBEEF);

        // Requesters 0 and 2 request continuously: last grant was 0, so 2 goes first
        bus.sel = 6'b111111;
        bus.req = 3'b101;
        c0 = cyc; nseq = 0; ack1_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aseq[i] = '0;
            acy[i]  = -1;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ack != 3'b000) begin
                if (nseq < 4) begin
                    aseq[nseq] = bus.ack;
                    acy[nseq]  = cyc - c0;
                end
                nseq++;
            end
            if (bus.ack[1]) ack1_seen = 1'b1;
        end
        bus.req = '0;
        tick();
        chk("alt_count", nseq, 4);
        chk("alt_g0", aseq[0], 3'b100);
        chk("alt_g1", aseq[1], 3'b001);
        chk("alt_g2", aseq[2], 3'b100);
        chk("alt_g3", aseq[3], 3'b001);
        chk("alt_cyc1", acy[1], 9);
        chk("alt_cyc3", acy[3], 19);
        chk("alt_no_req1", ack1_seen, 0);

        // Reset during the ACCESS phase of a write
        bus.adr[0 +: AW]   = 18'h00055;
        bus.wdata[0 +: DW] = 16'hFFFF;
        bus.sel   = 6'b000011;
        bus.write = 3'b001;
        bus.req   = 3'b001;
        tick();
        tick();
        chk("mrst_access_we", bus.RAMWE, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_pins", {bus.RAMCS, bus.RAMWE, bus.RAMOE, bus.RAMLB, bus.RAMUB}, 5'b11111);
        chk("mrst_adr", bus.ADR, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_rdata", bus.rdata, 0);
        bus.adr[AW +: AW] = 18'h00010;
        bus.sel = 6'b001111;
        bus.req = 3'b011;
        tick();
        chk("mrst_hold_ack", bus.ack, 0);
        tick();
        chk("mrst_hold_busy", bus.busy, 0);
        rst_n = 1'b1;
        wait_ack(10, v, n);
        chk("mrst_first_grant", v, 3'b001);
        chk("mrst_first_lat", n, 4);
        bus.req[0] = 1'b0;
        bus.write  = '0;
        wait_ack(10, v, n);
        chk("mrst_second_grant", v, 3'b010);
        chk("mrst_second_lat", n, 5);
        chk("mrst_second_rdata", bus.rdata, 16'h1111);
        bus.req = '0;
        tick();

        // WAIT=0 and WAIT=15 instances, read of 0x00ABC returns 0x0ABC ^ 0xC3C3
        bus0.adr[0 +: AW]  = 18'h00ABC;
        bus0.sel           = 6'b000011;
        bus15.adr[0 +: AW] = 18'h00ABC;
        bus15.sel          = 6'b000011;
        bus0.req  = 3'b001;
        bus15.req = 3'b001;
        c0 = cyc; oe0 = 0; oe15 = 0; c_a0 = -1; c_a15 = -1;
        v0 = '0; v15 = '0; rd0 = '0; rd15 = '0;
        for (int k = 0; k < 22; k++) begin
            tick();
            if (!bus0.RAMOE) oe0++;
            if (!bus15.RAMOE) oe15++;
            if (bus0.ack != 3'b000) begin
                c_a0 = cyc - c0; v0 = bus0.ack; rd0 = bus0.rdata; bus0.req = '0;
            end
            if (bus15.ack != 3'b000) begin
                c_a15 = cyc - c0; v15 = bus15.ack; rd15 = bus15.rdata; bus15.req = '0;
            end
        end
        chk("w0_ack_cyc", c_a0, 3);
        chk("w0_ack_vec", v0, 3'b001);
        chk("w0_rdata", rd0, 16'hC97F);
        chk("w0_oe_low", oe0, 2);
        chk("w15_ack_cyc", c_a15, 18);
        chk("w15_ack_vec", v15, 3'b001);
        chk("w15_rdata", rd15, 16'hC97F);
        chk("w15_oe_low", oe15, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
